// File: rtl/freq_cursor_pkg.sv
// freq_cursor_pkg: shared constants and types for the frequency-to-cursor-span path.
// Optional build macro: FREQ_CURSOR_ROUND_EN (round-to-nearest quotient, wider numerator).
package freq_cursor_pkg;

   // 96 samples per division x 15360
   localparam int SCOPE_NUMERATOR = 1474560;

   localparam int BIN_W     = 17;
   localparam int DIVISOR_W = 23;
   localparam int QUOT_W    = 21;

`ifdef FREQ_CURSOR_ROUND_EN
   // numerator gains divisor/2, so it needs the full divisor width
   localparam int NUM_W     = DIVISOR_W;
   localparam int LAT_VALID = 31;
`else
   localparam int NUM_W     = QUOT_W;
   localparam int LAT_VALID = 29;
`endif
   localparam int LAT_ERROR = 2;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      CONVERT,
      MULT,
      DIV,
      DONE
   } state_t;

endpackage

// File: rtl/freq_to_cursor_span_serial_divider.sv
// serial_divider: restoring divider, one quotient bit per clock, NUM_W iterations.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   start           load numerator/divisor when idle
//   numerator       dividend, NUM_W bits
//   divisor         divisor, DEN_W bits, must be non-zero
//   done            high in the cycle of the final iteration
//   quotient        final quotient, valid while done is high
module serial_divider #(
   parameter int NUM_W = 21,
   parameter int DEN_W = 23
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [NUM_W-1:0] numerator,
   input  logic [DEN_W-1:0] divisor,
   output logic             done,
   output logic [NUM_W-1:0] quotient
);

   localparam int CNT_W = $clog2(NUM_W + 1);

   logic             busy_q;
   logic [CNT_W-1:0] cnt_q;
   // numerator bits shift out of the top while quotient bits shift in at the bottom
   logic [NUM_W-1:0] num_q;
   logic [DEN_W-1:0] den_q;
   logic [DEN_W-1:0] rem_q;

   logic [DEN_W:0]   rem_shift;
   logic [DEN_W:0]   rem_sub;
   logic             fits;

   always_comb begin
      rem_shift = {rem_q, num_q[NUM_W-1]};
      rem_sub   = rem_shift - {1'b0, den_q};
      // rem_shift < 2*divisor, so the top bit of the difference is the borrow
      fits      = ~rem_sub[DEN_W];
      quotient  = {num_q[NUM_W-2:0], fits};
      done      = busy_q && (cnt_q == CNT_W'(1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         num_q  <= '0;
         den_q  <= '0;
         rem_q  <= '0;
      end else if (busy_q) begin
         rem_q <= fits ? rem_sub[DEN_W-1:0] : rem_shift[DEN_W-1:0];
         num_q <= quotient;
         cnt_q <= cnt_q - CNT_W'(1);
         if (done) busy_q <= 1'b0;
      end else if (start) begin
         num_q  <= numerator;
         den_q  <= divisor;
         rem_q  <= '0;
         cnt_q  <= CNT_W'(NUM_W);
         busy_q <= 1'b1;
      end
   end

endmodule

// File: rtl/freq_to_cursor_span.sv
// freq_to_cursor_span: converts a 5-digit BCD frequency into a cursor span
//   Span = 1474560 / (TimeScale * freq), Right_Cursor = Left_Cursor + Span (clamped).
// Optional build macro: FREQ_CURSOR_ROUND_EN (round-to-nearest, 31-cycle latency).
// Ports:
//   Main_CLK, Main_RST_n   clock, async active-low reset
//   Start                  request, sampled only in IDLE
//   Freq_BCD               5 BCD digits in Hz, [19:16] most significant
//   TimeScale              horizontal scale, 1..63
//   Left_Cursor            anchor cursor
//   Busy, Done             handshake; Done pulses for one cycle
//   Span, Right_Cursor     results, held until next Done or reset
//   Err, Sat               invalid request / saturated or clamped result
//
// state   | meaning
// IDLE    | waiting for Start
// CHECK   | validate latched digits and scale
// CONVERT | BCD to binary, one digit per cycle, MSD first
// MULT    | divisor = TimeScale * bin, divider loaded
// DIV     | serial division running
// DONE    | results valid, Done pulse
module freq_to_cursor_span
   import freq_cursor_pkg::*;
#(
   parameter int CURSOR_MAX = 511,
   parameter int SPAN_W     = 9
) (
   input  logic              Main_CLK,
   input  logic              Main_RST_n,
   input  logic              Start,
   input  logic [19:0]       Freq_BCD,
   input  logic [5:0]        TimeScale,
   input  logic [SPAN_W-1:0] Left_Cursor,
   output logic              Busy,
   output logic              Done,
   output logic [SPAN_W-1:0] Span,
   output logic [SPAN_W-1:0] Right_Cursor,
   output logic              Err,
   output logic              Sat
);

   localparam int SPAN_MAX = (1 << SPAN_W) - 1;

   state_t state_q, state_d;

   logic [19:0]          freq_q;
   logic [5:0]           ts_q;
   logic [SPAN_W-1:0]    left_q;
   logic [BIN_W-1:0]     bin_q;
   logic [2:0]           digit_cnt;

   logic [SPAN_W-1:0]    span_q;
   logic [SPAN_W-1:0]    right_q;
   logic                 err_q;
   logic                 sat_q;

   logic                 digit_bad;
   logic                 input_bad;
   logic [BIN_W-1:0]     bin_times_ten;
   logic [DIVISOR_W-1:0] product;
   logic [NUM_W-1:0]     numerator;
   logic                 div_start;
   logic                 div_done;
   logic [NUM_W-1:0]     div_quot;

   logic                 span_over;
   logic [SPAN_W-1:0]    span_c;
   logic [SPAN_W:0]      sum_c;
   logic                 clamp_c;
   logic [SPAN_W-1:0]    right_c;

   always_comb begin
      digit_bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (freq_q[4*i +: 4] > 4'd9) digit_bad = 1'b1;
      end
      input_bad     = digit_bad || (freq_q == '0) || (ts_q == '0);
      bin_times_ten = (bin_q << 3) + (bin_q << 1);
      product       = DIVISOR_W'(ts_q) * DIVISOR_W'(bin_q);
`ifdef FREQ_CURSOR_ROUND_EN
      numerator     = NUM_W'(SCOPE_NUMERATOR) + NUM_W'(product >> 1);
`else
      numerator     = NUM_W'(SCOPE_NUMERATOR);
`endif
      div_start     = (state_q == MULT);

      span_over = (div_quot > NUM_W'(SPAN_MAX));
      span_c    = span_over ? '1 : div_quot[SPAN_W-1:0];
      sum_c     = {1'b0, left_q} + {1'b0, span_c};
      clamp_c   = (sum_c > (SPAN_W+1)'(CURSOR_MAX));
      right_c   = clamp_c ? SPAN_W'(CURSOR_MAX) : sum_c[SPAN_W-1:0];
   end

   serial_divider #(
      .NUM_W (NUM_W),
      .DEN_W (DIVISOR_W)
   ) u_div (
      .clk       (Main_CLK),
      .rst_n     (Main_RST_n),
      .start     (div_start),
      .numerator (numerator),
      .divisor   (product),
      .done      (div_done),
      .quotient  (div_quot)
   );

   always_ff @(posedge Main_CLK or negedge Main_RST_n) begin
      if (!Main_RST_n) state_q <= IDLE;
      else             state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (Start) state_d = CHECK;
         CHECK:   state_d = input_bad ? DONE : CONVERT;
         CONVERT: if (digit_cnt == 3'd0) state_d = MULT;
         MULT:    state_d = DIV;
         DIV:     if (div_done) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Main_CLK or negedge Main_RST_n) begin
      if (!Main_RST_n) begin
         freq_q    <= '0;
         ts_q      <= '0;
         left_q    <= '0;
         bin_q     <= '0;
         digit_cnt <= '0;
         span_q    <= '0;
         right_q   <= '0;
         err_q     <= 1'b0;
         sat_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (Start) begin
                  freq_q    <= Freq_BCD;
                  ts_q      <= TimeScale;
                  left_q    <= Left_Cursor;
                  bin_q     <= '0;
                  digit_cnt <= 3'd4;
               end
            end
            CHECK: begin
               if (input_bad) begin
                  err_q   <= 1'b1;
                  span_q  <= '0;
                  right_q <= left_q;
                  sat_q   <= 1'b0;
               end
            end
            CONVERT: begin
               bin_q     <= bin_times_ten + BIN_W'(freq_q[19:16]);
               freq_q    <= {freq_q[15:0], 4'h0};
               digit_cnt <= digit_cnt - 3'd1;
            end
            DIV: begin
               // capture on the final iteration so results are valid during DONE
               if (div_done) begin
                  err_q   <= 1'b0;
                  span_q  <= span_c;
                  right_q <= right_c;
                  sat_q   <= span_over || clamp_c;
               end
            end
            default: ;
         endcase
      end
   end

   assign Busy         = (state_q != IDLE) && (state_q != DONE);
   assign Done         = (state_q == DONE);
   assign Span         = span_q;
   assign Right_Cursor = right_q;
   assign Err          = err_q;
   assign Sat          = sat_q;

endmodule

// File: tb/tb_freq_to_cursor_span.sv
// Bench for freq_to_cursor_span: arithmetic reference model checked every cycle,
// plus directed requests with hand-computed results.
module tb_freq_to_cursor_span;

`ifdef FREQ_CURSOR_ROUND_EN
   localparam int LAT_OK = 31;
   localparam bit ROUND  = 1'b1;
`else
   localparam int LAT_OK = 29;
   localparam bit ROUND  = 1'b0;
`endif
   localparam int LAT_BAD = 2;
   localparam int CUR_MAX = 511;

   logic        Main_CLK = 1'b0;
   logic        Main_RST_n = 1'b0;
   logic        Start = 1'b0;
   logic [19:0] Freq_BCD = '0;
   logic [5:0]  TimeScale = '0;
   logic [8:0]  Left_Cursor = '0;
   logic        Busy, Done, Err, Sat;
   logic [8:0]  Span, Right_Cursor;

   int tests = 0;
   int fails = 0;

   freq_to_cursor_span dut (
      .Main_CLK     (Main_CLK),
      .Main_RST_n   (Main_RST_n),
      .Start        (Start),
      .Freq_BCD     (Freq_BCD),
      .TimeScale    (TimeScale),
      .Left_Cursor  (Left_Cursor),
      .Busy         (Busy),
      .Done         (Done),
      .Span         (Span),
      .Right_Cursor (Right_Cursor),
      .Err          (Err),
      .Sat          (Sat)
   );

   always #5 Main_CLK = ~Main_CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic       err;
      logic       sat;
      logic [8:0] span;
      logic [8:0] right;
      logic [5:0] lat;
   } res_t;

   function automatic res_t model(input logic [19:0] f, input logic [5:0] ts, input logic [8:0] left);
      res_t   r;
      longint fv, dig, d, q, sum;
      bit     bad;
      r   = '0;
      fv  = 0;
      bad = (f == 20'h0) || (ts == 6'd0);
      for (int i = 4; i >= 0; i--) begin
         dig = longint'((f >> (4*i)) & 20'hF);
         if (dig > 9) bad = 1'b1;
         fv = fv * 10 + dig;
      end
      if (bad) begin
         r.err   = 1'b1;
         r.right = left;
         r.lat   = 6'(LAT_BAD);
      end else begin
         d = longint'(ts) * fv;
         q = ROUND ? (1474560 + d / 2) / d : 1474560 / d;
         if (q > 511) begin
            r.sat = 1'b1;
            q = 511;
         end
         r.span = 9'(q);
         sum = longint'(left) + q;
         if (sum > CUR_MAX) begin
            r.sat   = 1'b1;
            r.right = 9'(CUR_MAX);
         end else begin
            r.right = 9'(sum);
         end
         r.lat = 6'(LAT_OK);
      end
      return r;
   endfunction

   // cycle-level expectation: m_cnt counts cycles since the accepting edge
   logic       m_active;
   logic [5:0] m_cnt;
   res_t       m_pend;
   logic       m_err, m_sat;
   logic [8:0] m_span, m_right;
   logic       m_busy, m_done;

   always @(posedge Main_CLK or negedge Main_RST_n) begin
      if (!Main_RST_n) begin
         m_active <= 1'b0;
         m_cnt    <= '0;
         m_pend   <= '0;
         m_err    <= 1'b0;
         m_sat    <= 1'b0;
         m_span   <= '0;
         m_right  <= '0;
      end else if (!m_active) begin
         if (Start) begin
            m_active <= 1'b1;
            m_cnt    <= 6'd1;
            m_pend   <= model(Freq_BCD, TimeScale, Left_Cursor);
         end
      end else if (m_cnt == m_pend.lat) begin
         m_active <= 1'b0;
      end else begin
         m_cnt <= m_cnt + 6'd1;
         if (m_cnt + 6'd1 == m_pend.lat) begin
            m_err   <= m_pend.err;
            m_sat   <= m_pend.sat;
            m_span  <= m_pend.span;
            m_right <= m_pend.right;
         end
      end
   end

   assign m_busy = m_active && (m_cnt != m_pend.lat);
   assign m_done = m_active && (m_cnt == m_pend.lat);

   always @(negedge Main_CLK) begin
      check("busy",  32'(Busy),         32'(m_busy));
      check("done",  32'(Done),         32'(m_done));
      check("err",   32'(Err),          32'(m_err));
      check("sat",   32'(Sat),          32'(m_sat));
      check("span",  32'(Span),         32'(m_span));
      check("right", 32'(Right_Cursor), 32'(m_right));
   end

   // wait for Done starting from cycle count n, bounded
   task automatic wait_done(inout int n);
      while (!Done && n < 80) begin
         @(negedge Main_CLK);
         n++;
      end
   endtask

   task automatic run_req(input string name, input logic [19:0] f, input logic [5:0] ts,
                          input logic [8:0] left, input int e_span, input int e_right,
                          input int e_sat, input int e_err, input int e_lat);
      int n;
      Freq_BCD    = f;
      TimeScale   = ts;
      Left_Cursor = left;
      Start       = 1'b1;
      @(negedge Main_CLK);
      Start = 1'b0;
      n = 1;
      wait_done(n);
      check({name, "_lat"},   32'(n),            32'(e_lat));
      check({name, "_span"},  32'(Span),         32'(e_span));
      check({name, "_right"}, 32'(Right_Cursor), 32'(e_right));
      check({name, "_sat"},   32'(Sat),          32'(e_sat));
      check({name, "_err"},   32'(Err),          32'(e_err));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int dones;
      Main_RST_n = 1'b0;
      repeat (3) @(negedge Main_CLK);
      check("rst_busy",  32'(Busy),         0);
      check("rst_done",  32'(Done),         0);
      check("rst_span",  32'(Span),         0);
      check("rst_right", 32'(Right_Cursor), 0);
      Main_RST_n = 1'b1;
      @(negedge Main_CLK);

      run_req("f3000",  20'h03000, 6'd1,  9'd0,   ROUND ? 492 : 491, ROUND ? 492 : 491, 0, 0, LAT_OK);
      @(negedge Main_CLK);
      run_req("f1000",  20'h01000, 6'd10, 9'd400, 147, 511, 1, 0, LAT_OK);
      @(negedge Main_CLK);
      run_req("f1",     20'h00001, 6'd1,  9'd0,   511, 511, 1, 0, LAT_OK);
      @(negedge Main_CLK);
      run_req("f12345", 20'h12345, 6'd1,  9'd7,   119, 126, 0, 0, LAT_OK);
      @(negedge Main_CLK);
      run_req("fmax",   20'h99999, 6'd63, 9'd511, 0,   511, 0, 0, LAT_OK);
      @(negedge Main_CLK);
      run_req("ebcd",   20'h0A000, 6'd5,  9'd33,  0,   33,  0, 1, LAT_BAD);
      @(negedge Main_CLK);
      run_req("ezero",  20'h00000, 6'd5,  9'd34,  0,   34,  0, 1, LAT_BAD);
      @(negedge Main_CLK);
      run_req("ets",    20'h03000, 6'd0,  9'd44,  0,   44,  0, 1, LAT_BAD);

      // Start re-pulsed mid-operation must be ignored
      @(negedge Main_CLK);
      Freq_BCD = 20'h00050; TimeScale = 6'd60; Left_Cursor = 9'd10;
      Start = 1'b1;
      @(negedge Main_CLK);
      Start = 1'b0;
      n = 1;
      while (n < 10) begin
         @(negedge Main_CLK);
         n++;
      end
      Freq_BCD = 20'h00001; TimeScale = 6'd1; Left_Cursor = 9'd0;
      Start = 1'b1;
      @(negedge Main_CLK);
      Start = 1'b0;
      n++;
      wait_done(n);
      check("repulse_lat",   32'(n),            32'(LAT_OK));
      check("repulse_span",  32'(Span),         ROUND ? 492 : 491);
      check("repulse_right", 32'(Right_Cursor), ROUND ? 502 : 501);

      // accepted in the cycle right after Done
      @(negedge Main_CLK);
      run_req("b2b", 20'h01000, 6'd10, 9'd400, 147, 511, 1, 0, LAT_OK);

      // reset mid-operation
      @(negedge Main_CLK);
      Freq_BCD = 20'h03000; TimeScale = 6'd1; Left_Cursor = 9'd0;
      Start = 1'b1;
      @(negedge Main_CLK);
      Start = 1'b0;
      n = 1;
      while (n < 15) begin
         @(negedge Main_CLK);
         n++;
      end
      Main_RST_n = 1'b0;
      #1;
      check("mrst_busy",  32'(Busy),         0);
      check("mrst_done",  32'(Done),         0);
      check("mrst_span",  32'(Span),         0);
      check("mrst_right", 32'(Right_Cursor), 0);
      check("mrst_sat",   32'(Sat),          0);
      check("mrst_err",   32'(Err),          0);
      repeat (2) @(negedge Main_CLK);
      Main_RST_n = 1'b1;
      dones = 0;
      repeat (40) begin
         @(negedge Main_CLK);
         if (Done) dones++;
      end
      check("mrst_no_done", 32'(dones), 0);
      run_req("after_rst", 20'h03000, 6'd1, 9'd0, ROUND ? 492 : 491, ROUND ? 492 : 491, 0, 0, LAT_OK);

      repeat (3) @(negedge Main_CLK);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
